// File: rtl/me_pkg.sv
// me_pkg: shared types and width helpers for the motion-estimation search engine.
//   me_state_t : search FSM states (IDLE/RUN/FLUSH/DONE)
//   sad_w/mv_w/r_aw/s_aw : clog2-derived widths from the block parameters
//   mv_of      : candidate offset -> signed motion-vector component
package me_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} me_state_t;

  localparam int ME_N_DEF     = 16;
  localparam int ME_RANGE_DEF = 8;
  localparam int ME_LANES_DEF = 4;
  localparam int ME_PIX_W_DEF = 8;

  // Exact SAD width: N*N terms of at most 2^PIX_W-1 each.
  function automatic int sad_w(input int pix_w, input int n);
    return pix_w + 2 * $clog2(n);
  endfunction

  function automatic int mv_w(input int range);
    return $clog2(range) + 1;
  endfunction

  function automatic int r_aw(input int n);
    return $clog2(n * n);
  endfunction

  function automatic int s_aw(input int n, input int range);
    return $clog2((n + 2 * range) * (n + 2 * range));
  endfunction

  // Window offset 0..2R-1 maps to vector -R..R-1.
  function automatic int mv_of(input int off, input int range);
    return off - range;
  endfunction

endpackage

// File: rtl/me_sad_lane.sv
// me_sad_lane: one candidate lane. Absolute difference of reference and
// window pixel, loaded on the first pixel of a group, accumulated otherwise.
//   clock, reset_n : clock, synchronous active-low reset
//   en             : pixel valid this cycle
//   first          : first pixel of a group (load instead of add)
//   r, s           : reference / window pixel
//   sum            : accumulator value including this cycle's pixel
module me_sad_lane #(
  parameter int PIX_W = 8,
  parameter int SAD_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             first,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] s,
  output logic [SAD_W-1:0] sum
);

  logic [PIX_W:0]   diff;
  logic [SAD_W-1:0] acc;

  assign diff = (r >= s) ? ({1'b0, r} - {1'b0, s}) : ({1'b0, s} - {1'b0, r});
  assign sum  = first ? SAD_W'(diff) : acc + SAD_W'(diff);

  always_ff @(posedge clock) begin
    if (!reset_n)  acc <= '0;
    else if (en)   acc <= sum;
  end

endmodule

// File: rtl/me_search_engine.sv
// me_search_engine: full-search block-matching motion estimator.
// Scans oy, then groups of LANES x-offsets, then every pixel of the block;
// one pixel position per cycle, LANES candidates in parallel. Each group's
// lane totals are snapshotted on its last pixel and compared the next cycle.
//   clock, reset_n   : clock, synchronous active-low reset
//   start/busy/done  : search handshake (done is a one-cycle pulse)
//   r_addr/r_data    : reference block read port (combinational read)
//   s_addr/s_data    : search window read port, LANES pixels wide
//   best_sad, mv_x, mv_y : minimum SAD and its signed motion vector
// Optional: define ME_ZERO_BIAS_EN to let the zero vector win on SAD ties.
module me_search_engine import me_pkg::*; #(
  parameter int N     = ME_N_DEF,
  parameter int RANGE = ME_RANGE_DEF,
  parameter int LANES = ME_LANES_DEF,
  parameter int PIX_W = ME_PIX_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [r_aw(N)-1:0]          r_addr,
  input  logic [PIX_W-1:0]            r_data,
  output logic [s_aw(N, RANGE)-1:0]   s_addr,
  input  logic [LANES*PIX_W-1:0]      s_data,
  output logic [sad_w(PIX_W, N)-1:0]  best_sad,
  output logic [mv_w(RANGE)-1:0]      mv_x,
  output logic [mv_w(RANGE)-1:0]      mv_y
);

  localparam int SW    = N + 2 * RANGE;
  localparam int SAD_W = sad_w(PIX_W, N);
  localparam int MV_W  = mv_w(RANGE);
  localparam int SAW   = s_aw(N, RANGE);
  localparam int JW    = $clog2(N);
  localparam int OW    = $clog2(2 * RANGE);
  localparam int NG    = 2 * RANGE / LANES;

  me_state_t state;
  logic [JW-1:0] i_cnt, j_cnt;
  logic [OW-1:0] g_cnt, oy_cnt, snap_g, snap_oy;
  logic          snap_vld;
  logic [LANES-1:0][SAD_W-1:0] lane_sum, snap_sad;

  logic run, first_pix, last_pix, last_grp, last_row;

  assign run       = (state == RUN);
  assign first_pix = (i_cnt == '0) && (j_cnt == '0);
  assign last_pix  = &{i_cnt, j_cnt};
  assign last_grp  = (g_cnt == OW'(NG - 1));
  assign last_row  = &oy_cnt;

  // N is a power of two, so i*N+j is a plain concatenation.
  assign r_addr = {i_cnt, j_cnt};
  assign s_addr = SAW'((int'(oy_cnt) + int'(i_cnt)) * SW
                       + int'(g_cnt) * LANES + int'(j_cnt));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    me_sad_lane #(.PIX_W(PIX_W), .SAD_W(SAD_W)) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (run),
      .first   (first_pix),
      .r       (r_data),
      .s       (s_data[k*PIX_W +: PIX_W]),
      .sum     (lane_sum[k])
    );
  end

  // Lane scan in x order keeps ties with the earliest candidate.
  logic [SAD_W-1:0] cmp_sad;
  logic [MV_W-1:0]  cmp_x, cmp_y;
  logic             win;
  int               cand_ox;

  always_comb begin
    cmp_sad = best_sad;
    cmp_x   = mv_x;
    cmp_y   = mv_y;
    win     = 1'b0;
    cand_ox = 0;
    for (int k = 0; k < LANES; k++) begin
      cand_ox = int'(snap_g) * LANES + k;
      win     = (snap_sad[k] < cmp_sad);
`ifdef ME_ZERO_BIAS_EN
      if (int'(snap_oy) == RANGE && cand_ox == RANGE)
        win = (snap_sad[k] <= cmp_sad);
`endif
      if (win) begin
        cmp_sad = snap_sad[k];
        cmp_x   = MV_W'(mv_of(cand_ox, RANGE));
        cmp_y   = MV_W'(mv_of(int'(snap_oy), RANGE));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      best_sad <= '1;
      mv_x     <= '0;
      mv_y     <= '0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      g_cnt    <= '0;
      oy_cnt   <= '0;
      snap_vld <= 1'b0;
      snap_g   <= '0;
      snap_oy  <= '0;
      snap_sad <= '0;
    end else begin
      done     <= 1'b0;
      snap_vld <= 1'b0;
      if (snap_vld) begin
        best_sad <= cmp_sad;
        mv_x     <= cmp_x;
        mv_y     <= cmp_y;
      end
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          busy     <= 1'b1;
          best_sad <= '1;
          i_cnt    <= '0;
          j_cnt    <= '0;
          g_cnt    <= '0;
          oy_cnt   <= '0;
        end
        RUN: begin
          if (last_pix) begin
            snap_vld <= 1'b1;
            snap_sad <= lane_sum;
            snap_g   <= g_cnt;
            snap_oy  <= oy_cnt;
            if (last_grp && last_row) state <= FLUSH;
          end
          j_cnt <= j_cnt + 1'b1;
          if (&j_cnt) begin
            i_cnt <= i_cnt + 1'b1;
            if (&i_cnt) begin
              if (last_grp) begin
                g_cnt  <= '0;
                oy_cnt <= oy_cnt + 1'b1;
              end else begin
                g_cnt  <= g_cnt + 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/me_search_engine.md
# me_search_engine

Parametrised full-search block-matching motion estimator. It supersedes the fixed 16×16 / ±8 systolic SAD array. It reads an N×N reference block and a (N+2·RANGE)² search window from external memories, computes the exact sum of absolute differences (SAD) for every candidate offset using LANES parallel lanes, and reports the minimum SAD with a signed motion vector. It sits between the frame-buffer read ports and the vector writer, under a start/done handshake.

## Interface
- `N`, default 16: block edge in pixels; power of two, 4..32.
- `RANGE`, default 8: search range; candidates cover dx, dy in [-RANGE, RANGE-1]; power of two.
- `LANES`, default 4: candidate X positions evaluated in parallel; power of two that divides 2·RANGE.
- `PIX_W`, default 8: pixel width.
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: begin search; sampled only in IDLE.
- `busy`  out  1: high from the cycle after start is accepted until done.
- `done`  out  1: one-cycle pulse when results are valid.
- `r_addr`  out  clog2(N·N): reference pixel address, i·N+j.
- `r_data`  in  PIX_W: reference pixel, combinational read of `r_addr`.
- `s_addr`  out  clog2(SW·SW), SW=N+2·RANGE: row·SW+col of lane 0.
- `s_data`  in  LANES·PIX_W: pixels at s_addr+k; lane k uses bits [k·PIX_W +: PIX_W], combinational read.
- `best_sad`  out  SAD_W = PIX_W+2·log2(N): minimum SAD.
- `mv_x`, `mv_y`  out  log2(RANGE)+1 each: signed two's-complement vector (offset − RANGE).

## Operation
- States: IDLE → RUN → FLUSH → DONE → IDLE.
- In IDLE, `start`=1 → RUN. Best register is set to all-ones and the counters are cleared.
- RUN scan order, outer to inner: oy 0..2R-1; group g 0..2R/LANES-1 (ox0 = g·LANES); i 0..N-1; j 0..N-1. One pixel position per cycle.
- Addresses: r_addr=i·N+j; s_addr=(oy+i)·SW+(ox0+j).
- Lane k computes |r − s_k| on PIX_W+1 bits, so there is no wrap.
- On the first pixel of a group (i=j=0), each lane loads the difference. Otherwise it adds the difference to its accumulator.
- SAD_W is exact, so there is no overflow and no saturation.
- On the last pixel of a group, lane totals and the group's (oy, ox0) are snapshotted.
- Next cycle the comparator scans lanes 0..LANES-1. A candidate replaces best if its SAD < best (strict). Ties therefore go to the earliest candidate in (oy, ox) raster order.
- After the last pixel of the last group → FLUSH (final compare) → DONE (done=1, busy=0) → IDLE.
- `start` while not in IDLE is ignored. `start` held high re-triggers only after return to IDLE.
- Outputs hold their last result until the next accepted start. At that start, best_sad is forced to all-ones and mv holds its old value until the first improvement.
- `reset_n`=0 at any cycle, including mid-search: on the next edge go to IDLE, and set busy=0, done=0, best_sad=all-ones, mv_x=mv_y=0, accumulators 0.

## Timing
- G = 2R·(2R/LANES) groups; each group takes N² cycles.
- Start accepted at edge E0. RUN occupies cycles 1..G·N², FLUSH is cycle G·N²+1, done is high in cycle G·N²+2.
- Defaults: G=64, done at cycle 16386.
- Addresses are registered-counter driven; the data path is one accumulate stage plus one compare stage.
- A group's compare overlaps the next group's first cycle.
- Reset values: busy 0, done 0, best_sad all-ones, mv_x 0, mv_y 0, r_addr 0, s_addr 0.

## Configuration
- `ME_ZERO_BIAS_EN` defined: the candidate at mv=(0,0) replaces best on SAD ≤ best. Every other candidate still requires strict <. Zero motion wins any tie it is part of.
- Not defined: pure strict <; earliest scanned candidate wins all ties.

## Structure
- Package `me_pkg`:
  - state enum (IDLE/RUN/FLUSH/DONE);
  - clog2-derived width localparams (SAD_W, MV_W, address widths);
  - helper function for signed MV conversion.
- Sub-module `me_sad_lane`: abs-diff plus load/accumulate register, instantiated LANES times via generate.
- Counters, FSM and comparator live in the top.

## Test plan
- Window copies the reference at ox=11, oy=5; all other window pixels differ by ≥1 → best_sad=0, mv_x=+3, mv_y=−3, done at cycle 16386.
- Reference all 0xFF, window all 0x00 → best_sad=65280, mv=(−8,−8).
- All pixels zero → mv=(−8,−8) without macro; mv=(0,0) with `ME_ZERO_BIAS_EN`.
- start re-pulsed at cycles 100 and 9000 → ignored; exactly one done pulse; results unchanged.
- reset_n low at cycle 5000 → next cycle busy=0, done=0, best_sad=0xFFFF, mv=0. A following start gives the correct result with full latency.
- N=8, RANGE=4, LANES=8 → G=8, done at cycle 514; planted match at offset (2,6) gives mv=(−2,+2), best_sad=0.
